vc_scheduler: RTL and testbench

VC_SCHEDULER -- requirements
Module: vc_scheduler

---
 rtl/vc_scheduler.sv | 135 +++++++++++++
 tb/tb_vc_scheduler.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/vc_scheduler.sv
// Two-VC weighted round-robin scheduler: VC0 gets up to WEIGHT back-to-back grants before a waiting VC1 is served.
// Optional grant statistics counters are built when VC_SCHED_STATS_EN is defined.
module vc_scheduler #(
  parameter int BW     = 6,
  parameter int WEIGHT = 3
) (
  input  logic          clk,
  input  logic          reset_L,
  input  logic          vc0_empty,
  input  logic          vc1_empty,
  input  logic [BW-1:0] vc0_data,
  input  logic [BW-1:0] vc1_data,
  input  logic          dest_almost_full,
  output logic          vc0_rd,
  output logic          vc1_rd,
  output logic [BW-1:0] data_out,
  output logic          valid_out,
  output logic          grant_vc,
  output logic [1:0]    state,
  output logic [7:0]    grant0_cnt,
  output logic [7:0]    grant1_cnt
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SERVE0 = 2'd1,
    SERVE1 = 2'd2,
    HOLD   = 2'd3
  } state_t;

  localparam logic [3:0] WMAX = 4'(WEIGHT);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [3:0]    r_wcnt;
  logic [3:0]    w_wcnt_nxt;
  logic          w_gnt0;
  logic          w_gnt1;
  logic [BW-1:0] r_data;
  logic          r_valid;
  logic          r_gvc;

  // Grant decision; gated by reset_L so no FIFO is read while reset is held.
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (reset_L && !dest_almost_full) begin
      if (!vc0_empty && (vc1_empty || (r_wcnt < WMAX)))
        w_gnt0 = 1'b1;
      else if (!vc1_empty)
        w_gnt1 = 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = IDLE;
    w_wcnt_nxt  = r_wcnt;
    if (dest_almost_full)
      w_state_nxt = HOLD;
    else if (w_gnt0)
      w_state_nxt = SERVE0;
    else if (w_gnt1)
      w_state_nxt = SERVE1;

    if (w_gnt0) begin
      if (vc1_empty)
        w_wcnt_nxt = 4'd0;
      else if (r_wcnt >= WMAX)
        w_wcnt_nxt = WMAX;
      else
        w_wcnt_nxt = r_wcnt + 4'd1;
    end else if (w_gnt1) begin
      w_wcnt_nxt = 4'd0;
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_state <= IDLE;
      r_wcnt  <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_wcnt  <= w_wcnt_nxt;
    end
  end

  // Output register: data and VC only change on a grant, valid tracks the grant.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_gvc   <= 1'b0;
    end else begin
      r_valid <= w_gnt0 | w_gnt1;
      if (w_gnt0) begin
        r_data <= vc0_data;
        r_gvc  <= 1'b0;
      end else if (w_gnt1) begin
        r_data <= vc1_data;
        r_gvc  <= 1'b1;
      end
    end
  end

`ifdef VC_SCHED_STATS_EN
  logic [7:0] r_cnt0;
  logic [7:0] r_cnt1;

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_cnt0 <= 8'd0;
      r_cnt1 <= 8'd0;
    end else begin
      if (w_gnt0 && (r_cnt0 != 8'hFF))
        r_cnt0 <= r_cnt0 + 8'd1;
      if (w_gnt1 && (r_cnt1 != 8'hFF))
        r_cnt1 <= r_cnt1 + 8'd1;
    end
  end

  assign grant0_cnt = r_cnt0;
  assign grant1_cnt = r_cnt1;
`else
  assign grant0_cnt = 8'd0;
  assign grant1_cnt = 8'd0;
`endif

  assign vc0_rd    = w_gnt0;
  assign vc1_rd    = w_gnt1;
  assign data_out  = r_data;
  assign valid_out = r_valid;
  assign grant_vc  = r_gvc;
  assign state     = r_state;

endmodule

// File: tb/tb_vc_scheduler.sv
// Directed and randomized bench for vc_scheduler against a queue-based reference model.
module tb_vc_scheduler;
  localparam int BW     = 6;
  localparam int WEIGHT = 3;

  logic          clk = 1'b0;
  logic          reset_L;
  logic          vc0_empty, vc1_empty;
  logic [BW-1:0] vc0_data, vc1_data;
  logic          dest_almost_full;
  logic          vc0_rd, vc1_rd;
  logic [BW-1:0] data_out;
  logic          valid_out;
  logic          grant_vc;
  logic [1:0]    state;
  logic [7:0]    grant0_cnt, grant1_cnt;

  vc_scheduler #(.BW(BW), .WEIGHT(WEIGHT)) dut (
    .clk(clk), .reset_L(reset_L),
    .vc0_empty(vc0_empty), .vc1_empty(vc1_empty),
    .vc0_data(vc0_data), .vc1_data(vc1_data),
    .dest_almost_full(dest_almost_full),
    .vc0_rd(vc0_rd), .vc1_rd(vc1_rd),
    .data_out(data_out), .valid_out(valid_out), .grant_vc(grant_vc),
    .state(state), .grant0_cnt(grant0_cnt), .grant1_cnt(grant1_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: the two FIFOs as queues plus the architectural registers.
  logic [BW-1:0] q0[$];
  logic [BW-1:0] q1[$];
  int m_wcnt, m_state, m_c0, m_c1;
  logic [BW-1:0] m_data;
  logic m_valid, m_gvc;
  int gseq[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_wcnt = 0; m_state = 0; m_c0 = 0; m_c1 = 0;
    m_data = '0; m_valid = 1'b0; m_gvc = 1'b0;
  endtask

  task automatic fill(input int n0, input int n1);
    for (int i = 0; i < n0; i++) q0.push_back(BW'($urandom_range(0, 63)));
    for (int i = 0; i < n1; i++) q1.push_back(BW'($urandom_range(0, 63)));
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".valid"}, 32'(valid_out), 32'(m_valid));
    chk({tag, ".data"},  32'(data_out),  32'(m_data));
    chk({tag, ".gvc"},   32'(grant_vc),  32'(m_gvc));
    chk({tag, ".state"}, 32'(state),     32'(m_state));
    chk({tag, ".cnt0"},  32'(grant0_cnt), 32'(m_c0));
    chk({tag, ".cnt1"},  32'(grant1_cnt), 32'(m_c1));
  endtask

  // One clock: drive inputs, check strobes mid-cycle, then check registered outputs after the edge.
  task automatic step(input string tag, input logic daf);
    int g;
    logic e0, e1;
    e0 = (q0.size() == 0);
    e1 = (q1.size() == 0);
    dest_almost_full = daf;
    vc0_empty = e0;
    vc1_empty = e1;
    vc0_data  = e0 ? BW'($urandom_range(0, 63)) : q0[0];
    vc1_data  = e1 ? BW'($urandom_range(0, 63)) : q1[0];
    if (daf || (e0 && e1))              g = 0;
    else if (!e0 && (e1 || m_wcnt < WEIGHT)) g = 1;
    else                                g = 2;
    #2;
    chk({tag, ".rd0"}, 32'(vc0_rd), 32'(g == 1));
    chk({tag, ".rd1"}, 32'(vc1_rd), 32'(g == 2));
    @(posedge clk);
    #1;
    m_valid = (g != 0);
    if (g == 1) begin
      m_data = q0.pop_front(); m_gvc = 1'b0;
      m_wcnt = e1 ? 0 : ((m_wcnt + 1 > WEIGHT) ? WEIGHT : m_wcnt + 1);
`ifdef VC_SCHED_STATS_EN
      if (m_c0 < 255) m_c0++;
`endif
    end else if (g == 2) begin
      m_data = q1.pop_front(); m_gvc = 1'b1;
      m_wcnt = 0;
`ifdef VC_SCHED_STATS_EN
      if (m_c1 < 255) m_c1++;
`endif
    end
    m_state = daf ? 3 : g;
    check_outputs(tag);
  endtask

  initial begin
    int pat[8];
    pat = '{0, 0, 0, 1, 0, 0, 0, 1};
    reset_L = 1'b0;
    dest_almost_full = 1'b0;
    vc0_empty = 1'b1; vc1_empty = 1'b1;
    vc0_data = '0; vc1_data = '0;
    model_reset();
    #3;
    check_outputs("reset");
    chk("reset.rd0", 32'(vc0_rd), 32'd0);
    chk("reset.rd1", 32'(vc1_rd), 32'd0);
    @(posedge clk); #1;
    reset_L = 1'b1;

    // Both VCs loaded with 8 words: 0,0,0,1 pattern, then VC1 only.
    fill(8, 8);
    gseq.delete();
    for (int i = 0; i < 17; i++) begin
      step("burst", 1'b0);
      if (valid_out) gseq.push_back(int'(grant_vc));
    end
    chk("burst.count", 32'(gseq.size()), 32'd16);
    for (int i = 0; i < 8; i++) chk($sformatf("burst.pat%0d", i), 32'(gseq[i]), 32'(pat[i]));

    // VC1 alone with 5 words.
    fill(0, 5);
    for (int i = 0; i < 6; i++) step("vc1only", 1'b0);
    chk("vc1only.idle", 32'(state), 32'd0);

    // Backpressure for 4 cycles mid-stream.
    fill(10, 10);
    for (int i = 0; i < 2; i++) step("pre_hold", 1'b0);
    for (int i = 0; i < 4; i++) step("hold", 1'b1);
    while (q0.size() + q1.size() > 0) step("post_hold", 1'b0);
    step("post_hold", 1'b0);

    // Nothing to send.
    for (int i = 0; i < 5; i++) step("empty", 1'b0);

    // Asynchronous reset in the middle of a burst.
    fill(6, 6);
    for (int i = 0; i < 2; i++) step("pre_rst", 1'b0);
    #2;
    reset_L = 1'b0;
    vc0_empty = 1'b0; vc1_empty = 1'b0;
    #1;
    model_reset();
    check_outputs("async_rst");
    chk("async_rst.rd0", 32'(vc0_rd), 32'd0);
    chk("async_rst.rd1", 32'(vc1_rd), 32'd0);
    @(posedge clk); #1;
    check_outputs("in_rst");
    reset_L = 1'b1;
    step("after_rst", 1'b0);
    chk("after_rst.first_vc0", 32'(grant_vc), 32'd0);
    while (q0.size() + q1.size() > 0) step("after_rst", 1'b0);

    // Randomized traffic with random backpressure.
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 2) == 0) fill(1, 0);
      if ($urandom_range(0, 2) == 0) fill(0, 1);
      step("rand", logic'($urandom_range(0, 4) == 0));
    end
    while (q0.size() + q1.size() > 0) step("rand_drain", 1'b0);

    // Long VC0-only run to push the grant counter past its limit.
    fill(300, 0);
    for (int i = 0; i < 301; i++) step("sat", 1'b0);
`ifdef VC_SCHED_STATS_EN
    chk("sat.cnt0_255", 32'(grant0_cnt), 32'd255);
`else
    chk("sat.cnt0_zero", 32'(grant0_cnt), 32'd0);
    chk("sat.cnt1_zero", 32'(grant1_cnt), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
